// File: rtl/phv_merger.sv
// phv_merger: reassembles 6B/4B/2B ALU results and the PHV remainder into a full PHV behind an output FIFO.
// Defining PHV_MERGER_STATS_EN adds the phv_out_cnt accepted-output counter.
module phv_merger #(
  parameter int PHV_LEN    = 1124,
  parameter int width_6B   = 48,
  parameter int width_4B   = 32,
  parameter int width_2B   = 16,
  parameter int REMAIN_LEN = PHV_LEN - 8*(width_6B+width_4B+width_2B),
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*width_6B-1:0] alu_6B_out,
  input  logic                  alu_6B_valid,
  input  logic [8*width_4B-1:0] alu_4B_out,
  input  logic                  alu_4B_valid,
  input  logic [8*width_2B-1:0] alu_2B_out,
  input  logic                  alu_2B_valid,
  input  logic [REMAIN_LEN-1:0] phv_remain_in,
  input  logic                  phv_remain_valid,
  output logic                  merger_ready,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic                  phv_out_valid,
  input  logic                  phv_out_ready,
  output logic                  err_timeout,
  output logic                  err_dup,
  output logic [15:0]           drop_cnt,
  output logic [31:0]           phv_out_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_FIFO} state_t;
  state_t state;
  logic [8*width_6B-1:0] d6;
  logic [8*width_4B-1:0] d4;
  logic [8*width_2B-1:0] d2;
  logic [REMAIN_LEN-1:0] dr;
  logic f6, f4, f2, fr;
  logic [AW-1:0] age;
  logic [PHV_LEN-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic go, c6, c4, c2, cr, dup, all_in, any_c, full, tmo, wr, rd;
  logic [PHV_LEN-1:0] asm_phv;
  always_comb begin
    go      = merger_ready && state != WAIT_FIFO;
    c6      = go && alu_6B_valid && !f6;
    c4      = go && alu_4B_valid && !f4;
    c2      = go && alu_2B_valid && !f2;
    cr      = go && phv_remain_valid && !fr;
    dup     = go && ((alu_6B_valid && f6) || (alu_4B_valid && f4) ||
                     (alu_2B_valid && f2) || (phv_remain_valid && fr));
    all_in  = (f6 || c6) && (f4 || c4) && (f2 || c2) && (fr || cr);
    any_c   = c6 || c4 || c2 || cr;
    full    = cnt == CW'(FIFO_DEPTH);
    tmo     = state == COLLECT && !all_in && age == AW'(TIMEOUT-1);
    wr      = all_in && !full;
    rd      = cnt != '0 && phv_out_ready;
    asm_phv = {c6 ? alu_6B_out : d6, c4 ? alu_4B_out : d4,
               c2 ? alu_2B_out : d2, cr ? phv_remain_in : dr};
  end
  assign phv_out_valid = cnt != '0;
  assign phv_out       = phv_out_valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= asm_phv;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      {f6, f4, f2, fr} <= '0;
      d6           <= '0;
      d4           <= '0;
      d2           <= '0;
      dr           <= '0;
      age          <= '0;
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
      merger_ready <= 1'b1;
      err_timeout  <= 1'b0;
      err_dup      <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      merger_ready <= state != WAIT_FIFO && !full;
      err_timeout  <= tmo;
      err_dup      <= err_dup || (dup && !tmo);
      if (c6) d6 <= alu_6B_out;
      if (c4) d4 <= alu_4B_out;
      if (c2) d2 <= alu_2B_out;
      if (cr) dr <= phv_remain_in;
      {f6, f4, f2, fr} <= (wr || tmo) ? 4'b0 : {f6 || c6, f4 || c4, f2 || c2, fr || cr};
      age   <= state == COLLECT ? age + AW'(1) : '0;
      // a complete set with a full FIFO parks in WAIT_FIFO until a slot frees
      state <= (wr || tmo) ? IDLE : all_in ? WAIT_FIFO : any_c ? COLLECT : state;
      if (tmo && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (wr) wp <= wp + PW'(1);
      if (rd) rp <= rp + PW'(1);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
`ifdef PHV_MERGER_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) phv_out_cnt <= '0;
    else if (phv_out_valid && phv_out_ready) phv_out_cnt <= phv_out_cnt + 32'd1;
`else
  assign phv_out_cnt = '0;
`endif
endmodule

// File: tb/tb_phv_merger.sv
// tb_phv_merger: directed stimulus with a scoreboard of expected assembled PHVs for phv_merger.
module tb_phv_merger;
  localparam int P  = 1124;
  localparam int RL = 356;
  logic clk = 0, rst = 1;
  logic [383:0] alu_6B_out = '0;
  logic [255:0] alu_4B_out = '0;
  logic [127:0] alu_2B_out = '0;
  logic [RL-1:0] phv_remain_in = '0;
  logic alu_6B_valid = 0, alu_4B_valid = 0, alu_2B_valid = 0, phv_remain_valid = 0;
  logic phv_out_ready = 1;
  logic merger_ready, phv_out_valid, err_timeout, err_dup;
  logic [P-1:0] phv_out;
  logic [15:0] drop_cnt;
  logic [31:0] phv_out_cnt;
  int tests = 0, fails = 0, hs = 0, to_pulses = 0, cyc = 0, last_to_cyc = 0;
  logic [P-1:0] exp_q[$];
  logic [383:0] v6;
  logic [255:0] v4;
  logic [127:0] v2;
  logic [RL-1:0] vr;

  phv_merger dut (
    .clk(clk), .rst(rst),
    .alu_6B_out(alu_6B_out), .alu_6B_valid(alu_6B_valid),
    .alu_4B_out(alu_4B_out), .alu_4B_valid(alu_4B_valid),
    .alu_2B_out(alu_2B_out), .alu_2B_valid(alu_2B_valid),
    .phv_remain_in(phv_remain_in), .phv_remain_valid(phv_remain_valid),
    .merger_ready(merger_ready), .phv_out(phv_out), .phv_out_valid(phv_out_valid),
    .phv_out_ready(phv_out_ready), .err_timeout(err_timeout), .err_dup(err_dup),
    .drop_cnt(drop_cnt), .phv_out_cnt(phv_out_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    logic [P-1:0] d;
    int hi, sh;
    tests++;
    if (act !== exp) begin
      fails++;
      d = act ^ exp;
      hi = 63;
      for (int i = 0; i < P; i++) if (d[i] !== 1'b0) hi = i;
      sh = hi < 63 ? 0 : hi - 63;
      $display("FAIL %s: bits[%0d+:64] got %h expected %h", name, sh, 64'(act >> sh), 64'(exp >> sh));
    end
  endtask

  // scoreboard: every accepted output must match the oldest expected PHV
  always @(negedge clk) begin
    if (rst) hs = 0;
    else begin
      if (err_timeout) begin to_pulses++; last_to_cyc = cyc; end
`ifdef PHV_MERGER_STATS_EN
      chk("phv_out_cnt", P'(phv_out_cnt), P'(hs));
`else
      chk("phv_out_cnt", P'(phv_out_cnt), P'(0));
`endif
      if (phv_out_valid && phv_out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got %h expected none", phv_out[P-1 -: 64]);
        end else chk("phv_out", phv_out, exp_q.pop_front());
        hs++;
      end
    end
  end

  function automatic logic [P-1:0] exp_phv();
    return {v6, v4, v2, vr};
  endfunction

  task automatic fill(input logic [7:0] s);
    v6 = {48{s}};
    v4 = {32{s ^ 8'h5A}};
    v2 = {16{s ^ 8'hC3}};
    vr = {4'h9, {44{s ^ 8'h3C}}};
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input bit a, input bit b, input bit c, input bit d);
    alu_6B_out = v6; alu_4B_out = v4; alu_2B_out = v2; phv_remain_in = vr;
    alu_6B_valid = a; alu_4B_valid = b; alu_2B_valid = c; phv_remain_valid = d;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!merger_ready && n < 50) begin tick(); n++; end
    chk("merger_ready_wait", P'(merger_ready), P'(1));
  endtask

  task automatic push(input logic [7:0] s);
    fill(s);
    wait_ready();
    set_in(1, 1, 1, 1);
    tick();
    set_in(0, 0, 0, 0);
    exp_q.push_back(exp_phv());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0, h0, n;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", P'(phv_out_valid), P'(0));
    chk("rst_phv", phv_out, P'(0));
    chk("rst_ready", P'(merger_ready), P'(1));
    chk("rst_tmo", P'(err_timeout), P'(0));
    chk("rst_dup", P'(err_dup), P'(0));
    chk("rst_drop", P'(drop_cnt), P'(0));
    rst = 0;
    tick(); tick();
    // all four groups in one cycle
    fill(8'h11);
    v6[383:336] = 48'hAABBCCDDEEFF;
    wait_ready();
    set_in(1, 1, 1, 1);
    tick();
    set_in(0, 0, 0, 0);
    exp_q.push_back(exp_phv());
    chk("t1_valid", P'(phv_out_valid), P'(1));
    chk("t1_c7", P'(phv_out[1123:1076]), P'(48'hAABBCCDDEEFF));
    tick();
    chk("t1_empty", P'(phv_out_valid), P'(0));
    // skewed arrival: 6B at 0, 4B at 2, 2B at 3, remain at 7
    fill(8'h22);
    for (int k = 0; k < 8; k++) begin
      set_in(k == 0, k == 2, k == 3, k == 7);
      tick();
      if (k == 7) exp_q.push_back(exp_phv());
      if (k < 7) chk("t2_hold", P'(phv_out_valid), P'(0));
    end
    set_in(0, 0, 0, 0);
    chk("t2_valid", P'(phv_out_valid), P'(1));
    chk("t2_2B", P'(phv_out[483:356]), P'({16{8'hE1}}));
    chk("t2_no_tmo", P'(to_pulses), P'(0));
    tick();
    // only 6B and 4B arrive -> timeout
    fill(8'h33);
    base = to_pulses;
    c0 = cyc;
    set_in(1, 0, 0, 0); tick();
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0);
    repeat (25) tick();
    chk("t3_pulses", P'(to_pulses), P'(base + 1));
    chk("t3_when", P'(last_to_cyc - c0 >= 15 && last_to_cyc - c0 <= 18), P'(1));
    chk("t3_drop", P'(drop_cnt), P'(1));
    chk("t3_no_out", P'(phv_out_valid), P'(0));
    chk("t3_ready", P'(merger_ready), P'(1));
    // back-pressure: five PHVs with downstream stalled
    phv_out_ready = 0;
    for (int s = 0; s < 5; s++) push(8'h40 + 8'(s));
    repeat (3) tick();
    chk("t4_ready_low", P'(merger_ready), P'(0));
    chk("t4_valid", P'(phv_out_valid), P'(1));
    chk("t4_head_2B", P'(phv_out[483:356]), P'({16{8'h83}}));
    chk("t4_pending", P'(exp_q.size()), P'(5));
    h0 = hs;
    phv_out_ready = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin tick(); n++; end
    chk("t4_drained", P'(exp_q.size()), P'(0));
    chk("t4_count", P'(hs - h0), P'(5));
    tick();
    // duplicate 2B valid keeps the first capture
    chk("t5_dup_before", P'(err_dup), P'(0));
    fill(8'h55);
    v2 = {8{16'h1111}};
    set_in(1, 0, 1, 0); tick();
    alu_6B_valid = 0;
    alu_2B_out = {8{16'h2222}};
    tick();
    set_in(0, 1, 0, 1); tick();
    set_in(0, 0, 0, 0);
    exp_q.push_back(exp_phv());
    chk("t5_valid", P'(phv_out_valid), P'(1));
    chk("t5_2B", P'(phv_out[483:356]), P'({8{16'h1111}}));
    chk("t5_dup", P'(err_dup), P'(1));
    tick();
    // async reset mid-collect with two FIFO entries
    phv_out_ready = 0;
    push(8'h60);
    push(8'h61);
    fill(8'h62);
    set_in(1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0); tick();
    chk("t6_pre_valid", P'(phv_out_valid), P'(1));
    #2 rst = 1;
    #1;
    chk("t6_valid", P'(phv_out_valid), P'(0));
    chk("t6_phv", phv_out, P'(0));
    chk("t6_ready", P'(merger_ready), P'(1));
    chk("t6_dup", P'(err_dup), P'(0));
    chk("t6_drop", P'(drop_cnt), P'(0));
    chk("t6_tmo", P'(err_timeout), P'(0));
    chk("t6_cnt", P'(phv_out_cnt), P'(0));
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 0;
    phv_out_ready = 1;
    tick();
    push(8'h63);
    chk("t6_after_valid", P'(phv_out_valid), P'(1));
    tick();
    chk("t6_after_empty", P'(exp_q.size()), P'(0));
    chk("t6_fifo_empty", P'(phv_out_valid), P'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
